// File: rtl/block_tile_renderer.sv
// Two-stage tile-pixel generator: ring distance -> shade code -> tinted RGB.
// Optional row-clear flashing is enabled by defining BLOCK_TILE_FLASH_EN.
module block_tile_renderer #(
  parameter int TILE_SIZE = 16,
  parameter int BEVEL_W   = 1,
  localparam int AW       = $clog2(TILE_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [AW-1:0] addr_x,
  input  logic [AW-1:0] addr_y,
  input  logic [1:0]    style,
  input  logic [11:0]   tint,
  input  logic          flash,
  input  logic          frame_tick,
  output logic          out_valid,
  output logic [11:0]   pixel_out,
  output logic          pix_opaque
);

  typedef enum logic [1:0] {
    SH_BORDER = 2'd0,
    SH_BEVEL  = 2'd1,
    SH_CENTRE = 2'd2,
    SH_CLEAR  = 2'd3
  } shade_e;

  localparam logic [AW-1:0] MAXC = AW'(TILE_SIZE - 1);
  localparam logic [AW-1:0] BW   = AW'(BEVEL_W);

  function automatic logic [AW-1:0] min2(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // MAXC - coord never underflows because coord spans at most MAXC.
  function automatic logic [AW-1:0] ring_dist(input logic [AW-1:0] x, input logic [AW-1:0] y);
    return min2(min2(x, y), min2(MAXC - x, MAXC - y));
  endfunction

  function automatic shade_e shade_of(input logic [AW-1:0] d, input logic [1:0] st);
    shade_e sh;
    sh = SH_CENTRE;
    case (st)
      2'd0:    sh = (d == '0) ? SH_BORDER : ((d <= BW) ? SH_BEVEL : SH_CENTRE);
      2'd1:    sh = (d == '0) ? SH_BORDER : SH_CENTRE;
      2'd2:    sh = (d == '0) ? SH_BORDER : SH_CLEAR;
      default: sh = (d <= BW) ? SH_BORDER : SH_CLEAR;
    endcase
    return sh;
  endfunction

  function automatic logic [4:0] mult_of(input shade_e sh);
    logic [4:0] m;
    case (sh)
      SH_BORDER: m = 5'd8;
      SH_BEVEL:  m = 5'd11;
      SH_CENTRE: m = 5'd16;
      default:   m = 5'd0;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] scale_ch(input logic [3:0] ch, input logic [4:0] m);
    logic [8:0] prod;
    prod = {5'd0, ch} * {4'd0, m};
    return prod[7:4];
  endfunction

  // Stage 0 -> 1: classify the coordinate into a shade code
  shade_e        shade_p0;
  logic          vld_p1_q;
  shade_e        shade_p1_q;
  logic [11:0]   tint_p1_q;

  assign shade_p0 = shade_of(ring_dist(addr_x, addr_y), style);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      shade_p1_q <= shade_p0;
      tint_p1_q  <= tint;
    end
  end

`ifdef BLOCK_TILE_FLASH_EN
  logic       flash_p1_q;
  logic [3:0] phase_q;

  always_ff @(posedge clk) begin
    if (in_valid) begin
      flash_p1_q <= flash;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= 4'd0;
    end else if (frame_tick) begin
      phase_q <= phase_q + 4'd1;
    end
  end
`else
  logic unused_flash_inputs;
  assign unused_flash_inputs = ^{flash, frame_tick};
`endif

  // Stage 1 -> 2: tint multiply, transparency and flash override
  logic        vld_p2_q;
  logic [11:0] pix_p2_q;
  logic        opq_p2_q;
  logic [11:0] pix_p2_d;
  logic        opq_p2_d;
  logic [4:0]  mult_p1;

  assign mult_p1 = mult_of(shade_p1_q);

  always_comb begin
    pix_p2_d = pix_p2_q;
    opq_p2_d = 1'b0;
    if (vld_p1_q) begin
      if (shade_p1_q == SH_CLEAR) begin
        pix_p2_d = 12'h000;
        opq_p2_d = 1'b0;
      end else begin
        pix_p2_d = {scale_ch(tint_p1_q[11:8], mult_p1),
                    scale_ch(tint_p1_q[7:4],  mult_p1),
                    scale_ch(tint_p1_q[3:0],  mult_p1)};
        opq_p2_d = 1'b1;
`ifdef BLOCK_TILE_FLASH_EN
        if (flash_p1_q && phase_q[3]) begin
          pix_p2_d = 12'hFFF;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2_q <= 1'b0;
      pix_p2_q <= 12'h000;
      opq_p2_q <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
      pix_p2_q <= pix_p2_d;
      opq_p2_q <= opq_p2_d;
    end
  end

  assign out_valid  = vld_p2_q;
  assign pixel_out  = pix_p2_q;
  assign pix_opaque = opq_p2_q;

endmodule

// File: tb/tb_block_tile_renderer.sv
// Directed bench for block_tile_renderer: three instances (16/1, 16/2, 32/1)
// driven from shared stimulus; flash expectations follow BLOCK_TILE_FLASH_EN.
module tb_block_tile_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  a16_x, a16_y;
  logic [4:0]  a32_x, a32_y;
  logic [1:0]  style;
  logic [11:0] tint;
  logic        flash;
  logic        frame_tick;

  logic        v0, v1, v2;
  logic [11:0] p0, p1, p2;
  logic        o0, o1, o2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  block_tile_renderer #(.TILE_SIZE(16), .BEVEL_W(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .addr_x(a16_x), .addr_y(a16_y),
    .style(style), .tint(tint), .flash(flash), .frame_tick(frame_tick),
    .out_valid(v0), .pixel_out(p0), .pix_opaque(o0));

  block_tile_renderer #(.TILE_SIZE(16), .BEVEL_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .addr_x(a16_x), .addr_y(a16_y),
    .style(style), .tint(tint), .flash(flash), .frame_tick(frame_tick),
    .out_valid(v1), .pixel_out(p1), .pix_opaque(o1));

  block_tile_renderer #(.TILE_SIZE(32), .BEVEL_W(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .addr_x(a32_x), .addr_y(a32_y),
    .style(style), .tint(tint), .flash(flash), .frame_tick(frame_tick),
    .out_valid(v2), .pixel_out(p2), .pix_opaque(o2));

  typedef struct {
    int          sel;
    int          x;
    int          y;
    logic [1:0]  st;
    logic [11:0] tn;
    logic [11:0] pix;
    logic        opq;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic sample(input int sel, output logic v, output logic [11:0] p, output logic o);
    case (sel)
      0: begin v = v0; p = p0; o = o0; end
      1: begin v = v1; p = p1; o = o1; end
      default: begin v = v2; p = p2; o = o2; end
    endcase
  endtask

  task automatic drive(input int x, input int y, input logic [1:0] st, input logic [11:0] tn,
                       input logic fl);
    in_valid = 1'b1;
    a16_x = 4'(x); a16_y = 4'(y);
    a32_x = 5'(x); a32_y = 5'(y);
    style = st; tint = tn; flash = fl;
  endtask

  // One isolated request: idle after 1 edge, valid after 2, idle/held after 3.
  task automatic apply(input int sel, input int x, input int y, input logic [1:0] st,
                       input logic [11:0] tn, input logic fl, input logic [11:0] ep,
                       input logic eo, input string nm);
    logic v; logic [11:0] p; logic o;
    @(negedge clk); drive(x, y, st, tn, fl);
    @(posedge clk); #1; sample(sel, v, p, o);
    check({nm, "_lat1"}, {31'd0, v}, 32'd0);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1; sample(sel, v, p, o);
    check(nm, {19'd0, v, o, p}, {19'd0, 1'b1, eo, ep});
    @(posedge clk); #1; sample(sel, v, p, o);
    check({nm, "_idle"}, {19'd0, v, o, p}, {19'd0, 1'b0, 1'b0, ep});
  endtask

  function automatic logic [12:0] model(input int x, input int y, input logic [1:0] st,
                                        input logic [11:0] t, input int ts, input int bw);
    int d, m, r, g, b;
    d = x;
    if (y < d) d = y;
    if (ts - 1 - x < d) d = ts - 1 - x;
    if (ts - 1 - y < d) d = ts - 1 - y;
    case (st)
      2'd0: m = (d == 0) ? 8 : ((d <= bw) ? 11 : 16);
      2'd1: m = (d == 0) ? 8 : 16;
      2'd2: m = (d == 0) ? 8 : 0;
      default: m = (d <= bw) ? 8 : 0;
    endcase
    if (m == 0) return 13'h0000;
    r = ((int'(t[11:8]) * m) >> 4) % 16;
    g = ((int'(t[7:4]) * m) >> 4) % 16;
    b = ((int'(t[3:0]) * m) >> 4) % 16;
    return {1'b1, 4'(r), 4'(g), 4'(b)};
  endfunction

  logic        ev[0:399];
  logic [12:0] eo_arr[0:399];
  logic [11:0] flash_exp;

  initial begin
    logic v; logic [11:0] p; logic o;
    int k, verr, perr, seen;

    rst_n = 1'b0; in_valid = 1'b0; a16_x = '0; a16_y = '0; a32_x = '0; a32_y = '0;
    style = 2'd0; tint = 12'h000; flash = 1'b0; frame_tick = 1'b0;

    tbl.push_back('{0, 0, 5, 2'd0, 12'hF84, 12'h742, 1'b1, "bev_border"});
    tbl.push_back('{0, 1, 7, 2'd0, 12'hF84, 12'hA52, 1'b1, "bev_bevel"});
    tbl.push_back('{0, 8, 8, 2'd0, 12'hF84, 12'hF84, 1'b1, "bev_centre"});
    tbl.push_back('{0, 15, 15, 2'd0, 12'h123, 12'h011, 1'b1, "bev_corner"});
    tbl.push_back('{0, 0, 0, 2'd1, 12'hFFF, 12'h777, 1'b1, "flat_border"});
    tbl.push_back('{0, 3, 4, 2'd1, 12'hFFF, 12'hFFF, 1'b1, "flat_centre"});
    tbl.push_back('{0, 5, 5, 2'd2, 12'hFFF, 12'h000, 1'b0, "ghost_inner"});
    tbl.push_back('{0, 15, 3, 2'd2, 12'hFFF, 12'h777, 1'b1, "ghost_edge"});
    tbl.push_back('{0, 1, 9, 2'd3, 12'hFFF, 12'h777, 1'b1, "hollow1_ring"});
    tbl.push_back('{0, 2, 9, 2'd3, 12'hFFF, 12'h000, 1'b0, "hollow1_clear"});
    tbl.push_back('{1, 2, 9, 2'd3, 12'hFFF, 12'h777, 1'b1, "hollow2_ring"});
    tbl.push_back('{1, 3, 9, 2'd3, 12'hFFF, 12'h000, 1'b0, "hollow2_clear"});
    tbl.push_back('{1, 2, 5, 2'd0, 12'hF84, 12'hA52, 1'b1, "bev2_bevel"});
    tbl.push_back('{1, 3, 5, 2'd0, 12'hF84, 12'hF84, 1'b1, "bev2_centre"});
    tbl.push_back('{2, 31, 31, 2'd0, 12'hFFF, 12'h777, 1'b1, "t32_maxcorner"});
    tbl.push_back('{2, 16, 16, 2'd0, 12'hF84, 12'hF84, 1'b1, "t32_centre"});
    tbl.push_back('{2, 0, 31, 2'd1, 12'h8C4, 12'h462, 1'b1, "t32_flat_edge"});

    // Reset held with valid requests presented.
    @(negedge clk); drive(8, 8, 2'd0, 12'hF84, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("reset_hold%0d", i), {19'd0, v0, o0, p0}, 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_release1", {19'd0, v0, o0, p0}, 32'd0);
    @(posedge clk); #1;
    check("reset_first_out", {19'd0, v0, o0, p0}, {19'd0, 1'b1, 1'b1, 12'hF84});
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(posedge clk);

    // Reset while a pixel is in stage 1: it must never emerge.
    @(negedge clk); drive(0, 5, 2'd0, 12'hF84, 1'b0);
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_during", {19'd0, v0, o0, p0}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("midreset_discard", {19'd0, v0, o0, p0}, 32'd0);

    foreach (tbl[i])
      apply(tbl[i].sel, tbl[i].x, tbl[i].y, tbl[i].st, tbl[i].tn, 1'b0,
            tbl[i].pix, tbl[i].opq, tbl[i].name);

    // Flash: phase is 0 after the last reset; 8 ticks set phase[3].
`ifdef BLOCK_TILE_FLASH_EN
    flash_exp = 12'hFFF;
`else
    flash_exp = 12'h0F0;
`endif
    apply(0, 8, 8, 2'd0, 12'h0F0, 1'b1, 12'h0F0, 1'b1, "flash_phase0");
    @(negedge clk); frame_tick = 1'b1;
    repeat (8) @(negedge clk);
    frame_tick = 1'b0;
    apply(0, 8, 8, 2'd0, 12'h0F0, 1'b1, flash_exp, 1'b1, "flash_8ticks");
    apply(0, 5, 5, 2'd2, 12'h0F0, 1'b1, 12'h000, 1'b0, "flash_transparent");
    @(negedge clk); frame_tick = 1'b1;
    repeat (8) @(negedge clk);
    frame_tick = 1'b0;
    apply(0, 8, 8, 2'd0, 12'h0F0, 1'b1, 12'h0F0, 1'b1, "flash_16ticks");

    // Streaming raster with a gap every third cycle.
    k = 0; verr = 0; perr = 0; seen = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ((c % 3) != 2 && k < 256) begin
        drive(k % 16, k / 16, 2'(k % 4), 12'(k * 37 + 12'h135), 1'b0);
        ev[c] = 1'b1;
        eo_arr[c] = model(k % 16, k / 16, 2'(k % 4), 12'(k * 37 + 12'h135), 16, 1);
        k++;
      end else begin
        in_valid = 1'b0;
        ev[c] = 1'b0;
        eo_arr[c] = 13'h0;
      end
      @(posedge clk); #1;
      if (c >= 1) begin
        sample(0, v, p, o);
        if (v !== ev[c-1]) verr++;
        if (ev[c-1]) begin
          if (v === 1'b1) seen++;
          if ({o, p} !== eo_arr[c-1]) perr++;
        end
      end
    end
    check("stream_valid_pattern_errors", verr, 0);
    check("stream_pixel_errors", perr, 0);
    check("stream_pixel_count", seen, 256);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
